// File: rtl/jianchu.sv
// Sequential subtract/divide unit: one-cycle 6-bit subtract, 6-step restoring divide,
// start/busy/done handshake with results held until the next completion.
module jianchu (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [5:0] a,
    input  logic [5:0] b,
    input  logic [1:0] sl,
    output logic       busy,
    output logic       done,
    output logic [6:0] c,
    output logic [5:0] r,
    output logic       err
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t     state_q;
    logic [2:0] cnt_q;
    logic [5:0] quo_q;
    logic [5:0] dvs_q;
    logic [5:0] rem_q;
    logic       busy_q;
    logic       done_q;
    logic [6:0] c_q;
    logic [5:0] r_q;
    logic       err_q;

    logic [6:0] trial;
    logic       ge;
    logic [5:0] rem_d;
    logic [5:0] quo_d;
    logic [6:0] sub_d;

    // quo_q starts as the dividend and fills with quotient bits as dividend bits shift out.
    always_comb begin
        trial = {rem_q, quo_q[5]};
        ge    = trial[6] | (trial[5:0] >= dvs_q);
        rem_d = ge ? (trial[5:0] - dvs_q) : trial[5:0];
        quo_d = {quo_q[4:0], ge};
        sub_d = {1'b0, a} - {1'b0, b};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            quo_q   <= 6'd0;
            dvs_q   <= 6'd0;
            rem_q   <= 6'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            c_q     <= 7'd0;
            r_q     <= 6'd0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        quo_q  <= a;
                        dvs_q  <= b;
                        rem_q  <= 6'd0;
                        busy_q <= 1'b1;
                        if (sl == 2'b11 && b != 6'd0) begin
                            state_q <= CALC;
                            cnt_q   <= 3'd5;
                        end else begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                            case (sl)
                                2'b00: begin
                                    c_q   <= sub_d;
                                    r_q   <= 6'd0;
                                    err_q <= 1'b0;
                                end
                                2'b11: begin
                                    c_q   <= 7'h7F;
                                    r_q   <= a;
                                    err_q <= 1'b1;
                                end
                                default: begin
                                    c_q   <= 7'd0;
                                    r_q   <= 6'd0;
                                    err_q <= 1'b1;
                                end
                            endcase
                        end
                    end
                end
                CALC: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    if (cnt_q == 3'd0) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                        c_q     <= {1'b0, quo_d};
                        r_q     <= rem_d;
                        err_q   <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign c    = c_q;
    assign r    = r_q;
    assign err  = err_q;

endmodule

// File: tb/tb_jianchu.sv
// Directed self-checking bench for jianchu: reset, subtract, divide, errors,
// busy-start rejection, back-to-back starts and mid-operation reset.
module tb_jianchu;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [5:0] a;
    logic [5:0] b;
    logic [1:0] sl;
    logic       busy;
    logic       done;
    logic [6:0] c;
    logic [5:0] r;
    logic       err;

    int checks = 0;
    int errors = 0;
    logic [6:0] lastC;

    jianchu dut (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start),
        .a    (a),
        .b    (b),
        .sl   (sl),
        .busy (busy),
        .done (done),
        .c    (c),
        .r    (r),
        .err  (err)
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b1;
        a = 6'd5; b = 6'd9; sl = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, c, r, err} !== 16'd0) begin
            errors++;
            $display("[TB] FAIL reset_outputs got busy=%b done=%b c=%h r=%h err=%b want all 0", busy, done, c, r, err);
        end
        start = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_start_ignored got busy=%b done=%b want 0 0", busy, done);
        end
        lastC = 7'd0;
    endtask

    task automatic test_subtract();
        logic [5:0] va [3] = '{6'd5, 6'd63, 6'd0};
        logic [5:0] vb [3] = '{6'd9, 6'd0, 6'd63};
        logic [6:0] vc [3] = '{7'h7C, 7'h3F, 7'h41};
        for (int i = 0; i < 3; i++) begin
            a = va[i]; b = vb[i]; sl = 2'b00; start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            checks++;
            if (done !== 1'b1 || busy !== 1'b1 || c !== vc[i] || r !== 6'd0 || err !== 1'b0) begin
                errors++;
                $display("[TB] FAIL sub_%0d got done=%b busy=%b c=%h r=%h err=%b want 1 1 %h 00 0", i, done, busy, c, r, err, vc[i]);
            end
            @(posedge clk); #1;
            checks++;
            if (done !== 1'b0 || busy !== 1'b0 || c !== vc[i]) begin
                errors++;
                $display("[TB] FAIL sub_after_%0d got done=%b busy=%b c=%h want 0 0 %h", i, done, busy, c, vc[i]);
            end
            lastC = vc[i];
        end
    endtask

    task automatic test_divide();
        logic [5:0] va [3] = '{6'd45, 6'd63, 6'd5};
        logic [5:0] vb [3] = '{6'd7, 6'd1, 6'd9};
        logic [6:0] vc [3] = '{7'd6, 7'd63, 7'd0};
        logic [5:0] vr [3] = '{6'd3, 6'd0, 6'd5};
        for (int i = 0; i < 3; i++) begin
            a = va[i]; b = vb[i]; sl = 2'b11; start = 1'b1;
            for (int k = 1; k <= 7; k++) begin
                @(posedge clk); #1;
                start = 1'b0;
                checks++;
                if (busy !== 1'b1 || done !== (k == 7)) begin
                    errors++;
                    $display("[TB] FAIL div_%0d_cycle%0d got busy=%b done=%b want 1 %b", i, k, busy, done, (k == 7));
                end
                if (k < 7) begin
                    checks++;
                    if (c !== lastC) begin
                        errors++;
                        $display("[TB] FAIL div_%0d_hold%0d got c=%h want %h", i, k, c, lastC);
                    end
                end
            end
            checks++;
            if (c !== vc[i] || r !== vr[i] || err !== 1'b0) begin
                errors++;
                $display("[TB] FAIL div_%0d_result got c=%0d r=%0d err=%b want %0d %0d 0", i, c, r, err, vc[i], vr[i]);
            end
            @(posedge clk); #1;
            checks++;
            if (busy !== 1'b0 || done !== 1'b0 || c !== vc[i] || r !== vr[i]) begin
                errors++;
                $display("[TB] FAIL div_%0d_after got busy=%b done=%b c=%0d r=%0d want 0 0 %0d %0d", i, busy, done, c, r, vc[i], vr[i]);
            end
            lastC = vc[i];
        end
    endtask

    task automatic test_errors();
        logic [5:0] va [3] = '{6'd20, 6'd12, 6'd40};
        logic [5:0] vb [3] = '{6'd0, 6'd3, 6'd2};
        logic [1:0] vs [3] = '{2'b11, 2'b01, 2'b10};
        logic [6:0] vc [3] = '{7'h7F, 7'h00, 7'h00};
        logic [5:0] vr [3] = '{6'd20, 6'd0, 6'd0};
        for (int i = 0; i < 3; i++) begin
            a = va[i]; b = vb[i]; sl = vs[i]; start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            checks++;
            if (done !== 1'b1 || c !== vc[i] || r !== vr[i] || err !== 1'b1) begin
                errors++;
                $display("[TB] FAIL err_%0d got done=%b c=%h r=%0d err=%b want 1 %h %0d 1", i, done, c, r, err, vc[i], vr[i]);
            end
            @(posedge clk); #1;
            checks++;
            if (done !== 1'b0 || busy !== 1'b0 || err !== 1'b1) begin
                errors++;
                $display("[TB] FAIL err_after_%0d got done=%b busy=%b err=%b want 0 0 1", i, done, busy, err);
            end
            lastC = vc[i];
        end
    endtask

    task automatic test_start_while_busy();
        a = 6'd45; b = 6'd7; sl = 2'b11; start = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            @(posedge clk); #1;
            start = (k == 3);
            if (k == 3) begin
                a = 6'd10; b = 6'd2; sl = 2'b00;
            end
            checks++;
            if (done !== (k == 7)) begin
                errors++;
                $display("[TB] FAIL busy_start_cycle%0d got done=%b want %b", k, done, (k == 7));
            end
        end
        checks++;
        if (c !== 7'd6 || r !== 6'd3 || err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL busy_start_result got c=%0d r=%0d err=%b want 6 3 0", c, r, err);
        end
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("[TB] FAIL busy_start_not_queued%0d got done=%b busy=%b want 0 0", k, done, busy);
            end
        end
    endtask

    task automatic test_back_to_back();
        a = 6'd45; b = 6'd7; sl = 2'b11; start = 1'b1;
        for (int i = 1; i <= 32; i++) begin
            @(posedge clk); #1;
            checks++;
            if (done !== (i % 8 == 7)) begin
                errors++;
                $display("[TB] FAIL b2b_cycle%0d got done=%b want %b", i, done, (i % 8 == 7));
            end
            if (i % 8 == 7) begin
                checks++;
                if (c !== 7'd6 || r !== 6'd3) begin
                    errors++;
                    $display("[TB] FAIL b2b_result%0d got c=%0d r=%0d want 6 3", i, c, r);
                end
            end
        end
        start = 1'b0;
    endtask

    task automatic test_mid_reset();
        a = 6'd63; b = 6'd5; sl = 2'b11; start = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        checks++;
        if ({busy, done, c, r, err} !== 16'd0) begin
            errors++;
            $display("[TB] FAIL mid_reset got busy=%b done=%b c=%h r=%h err=%b want all 0", busy, done, c, r, err);
        end
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("[TB] FAIL mid_reset_no_done%0d got done=%b busy=%b want 0 0", k, done, busy);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        a = 6'd0; b = 6'd0; sl = 2'b00;
        test_reset();
        test_subtract();
        test_divide();
        test_errors();
        test_start_while_busy();
        test_back_to_back();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
